// File: rtl/led_game_core.sv
// led_game_core: pattern-memory game engine for the LED board.
// A nonzero LFSR pattern is shown on the LEDs. The player then has a fixed
// window to copy it onto the switches. Each hit adds to a BCD score, and
// every POINTS_PER_LEVEL hits raise the level, which shortens the display.
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   start              - level-sensitive game enable (read in IDLE/OVER)
//   switch[N_LEDS]     - raw asynchronous player switches
//   led[N_LEDS]        - LED drive
//   seg_tens, seg_ones - active-low {g,f,e,d,c,b,a} score digits
//   level[4]           - current difficulty level
//   state[3]           - FSM state encoding
//   game_over          - high while in OVER
module led_game_core #(
  parameter int unsigned N_LEDS           = 10,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1,
  parameter int unsigned BASE_SHOW        = 32,
  parameter int unsigned SHOW_STEP        = 4,
  parameter int unsigned BASE_WINDOW      = 64,
  parameter int unsigned MAX_LEVEL        = 7,
  parameter int unsigned POINTS_PER_LEVEL = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [N_LEDS-1:0] switch,
  output logic [N_LEDS-1:0] led,
  output logic [6:0]        seg_tens,
  output logic [6:0]        seg_ones,
  output logic [3:0]        level,
  output logic [2:0]        state,
  output logic              game_over
);

  localparam int unsigned TW = 16;
  localparam int unsigned HW = $clog2(POINTS_PER_LEVEL + 1);
  localparam logic [N_LEDS-1:0] ALT = N_LEDS'(16'h5555);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_CLEAR = 3'd2,
    S_SHOW  = 3'd3,
    S_WAIT  = 3'd4,
    S_HIT   = 3'd5,
    S_OVER  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [N_LEDS-1:0] sw_meta_q, sw_s_q;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [N_LEDS-1:0] pattern_q, pattern_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        tens_q, tens_d, ones_q, ones_d;
  logic [3:0]        level_q, level_d;
  logic [HW-1:0]     hits_q, hits_d;
  logic [4:0]        blink_q, blink_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic [6:0]        seg_tens_q, seg_ones_q;
  logic              game_over_q, game_over_d;

  logic [15:0]       lfsr_shift;
  logic [31:0]       show_dec;
  logic [TW-1:0]     show_time;

  // Active-low seven-segment decode, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Fibonacci LFSR step, taps 16,14,13,11.
  assign lfsr_shift = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Display time shrinks with level, never below one cycle.
  assign show_dec  = 32'(level_q) * SHOW_STEP;
  assign show_time = (show_dec >= BASE_SHOW) ? TW'(1) : TW'(BASE_SHOW - show_dec);

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sw_meta_q   <= '0;
      sw_s_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      pattern_q   <= '0;
      timer_q     <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      level_q     <= '0;
      hits_q      <= '0;
      blink_q     <= '0;
      led_q       <= '0;
      seg_tens_q  <= 7'b1000000;
      seg_ones_q  <= 7'b1000000;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sw_meta_q   <= switch;
      sw_s_q      <= sw_meta_q;
      lfsr_q      <= lfsr_d;
      pattern_q   <= pattern_d;
      timer_q     <= timer_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      level_q     <= level_d;
      hits_q      <= hits_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
      // Decode the next digits so the score shows one cycle after HIT.
      seg_tens_q  <= seg7(tens_d);
      seg_ones_q  <= seg7(ones_d);
      game_over_q <= game_over_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    pattern_d = pattern_q;
    timer_d   = timer_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    level_d   = level_q;
    hits_d    = hits_q;
    blink_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_GEN;
          tens_d  = '0;
          ones_d  = '0;
          level_d = '0;
          hits_d  = '0;
        end
      end
      S_GEN: begin
        lfsr_d = lfsr_shift;
        if (lfsr_shift[N_LEDS-1:0] != '0) begin
          pattern_d = lfsr_shift[N_LEDS-1:0];
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (sw_s_q == '0) begin
          timer_d = show_time;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (timer_q <= TW'(1)) begin
          timer_d = TW'(BASE_WINDOW);
          state_d = S_WAIT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_WAIT: begin
        // A match on the last window cycle still counts as a hit.
        if (sw_s_q == pattern_q) begin
          state_d = S_HIT;
        end else if (timer_q <= TW'(1)) begin
          state_d = S_OVER;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_HIT: begin
        state_d = S_GEN;
        if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
          if (ones_q == 4'd9) begin
            ones_d = '0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end
        if (hits_q + HW'(1) == HW'(POINTS_PER_LEVEL)) begin
          hits_d = '0;
          if (level_q < 4'(MAX_LEVEL)) begin
            level_d = level_q + 4'd1;
          end
        end else begin
          hits_d = hits_q + HW'(1);
        end
      end
      S_OVER: begin
        blink_d = blink_q + 5'd1;
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs register with it.
  always_comb begin
    led_d       = '0;
    game_over_d = 1'b0;
    case (state_d)
      S_SHOW: led_d = pattern_d;
      S_HIT:  led_d = '1;
      S_OVER: begin
        game_over_d = 1'b1;
        led_d       = blink_d[4] ? ~ALT : ALT;
      end
      default: led_d = '0;
    endcase
  end

  assign led       = led_q;
  assign seg_tens  = seg_tens_q;
  assign seg_ones  = seg_ones_q;
  assign level     = level_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_led_game_core.sv
// tb_led_game_core: randomized self-checking bench for led_game_core.
module tb_led_game_core;

  localparam int unsigned N           = 10;
  localparam int          BASE_SHOW   = 32;
  localparam int          SHOW_STEP   = 4;
  localparam int          BASE_WINDOW = 64;
  localparam int          MAX_LEVEL   = 7;
  localparam int          PPL         = 4;
  localparam logic [15:0] SEED        = 16'hACE1;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] sw;
  logic [N-1:0] led;
  logic [6:0]   seg_tens, seg_ones;
  logic [3:0]   level;
  logic [2:0]   state;
  logic         game_over;

  led_game_core #(
    .N_LEDS(N), .LFSR_SEED(SEED), .BASE_SHOW(BASE_SHOW), .SHOW_STEP(SHOW_STEP),
    .BASE_WINDOW(BASE_WINDOW), .MAX_LEVEL(MAX_LEVEL), .POINTS_PER_LEVEL(PPL)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .switch(sw), .led(led),
    .seg_tens(seg_tens), .seg_ones(seg_ones), .level(level), .state(state),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
  logic [N-1:0] alt_a = 10'b0101010101;
  logic [N-1:0] all1  = '1;

  // Reference model state.
  logic [15:0] m_lfsr;
  int          m_score, m_level, m_hits;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1];
    return {s[14:0], fb};
  endfunction

  task automatic m_draw(output logic [N-1:0] p);
    do m_lfsr = lfsr_next(m_lfsr); while (m_lfsr[N-1:0] == '0);
    p = m_lfsr[N-1:0];
  endtask

  function automatic int m_show();
    int t;
    t = BASE_SHOW - m_level * SHOW_STEP;
    return (t < 1) ? 1 : t;
  endfunction

  task automatic m_reset_game();
    m_score = 0; m_level = 0; m_hits = 0;
  endtask

  task automatic m_hit();
    if (m_score < 99) m_score++;
    m_hits++;
    if (m_hits == PPL) begin
      m_hits = 0;
      if (m_level < MAX_LEVEL) m_level++;
    end
  endtask

  // One round from GEN/CLEAR onward. mode: 0 random hit, 1 hit on last
  // window cycle, 2 no answer, 3 answer one cycle too late.
  task automatic play_round(input int mode);
    logic [N-1:0] pat, wrong, p0;
    int k, d, show_len, wait_len;
    bit exp_hit;
    m_draw(pat);
    k = 0;
    while (state !== 3'd2 && k < 50) begin step(); k++; end
    n_cmp++;
    if (state !== 3'd2) begin
      n_err++; $display("FAIL reach_clear: state=%0d want 2", state); return;
    end
    if (sw !== '0) begin
      repeat ($urandom_range(1, 4)) step();
      n_cmp++;
      if (state !== 3'd2) begin n_err++; $display("FAIL clear_hold: state=%0d want 2", state); end
      sw = '0;
    end
    k = 0;
    while (state !== 3'd3 && k < 10) begin step(); k++; end
    n_cmp++;
    if (state !== 3'd3) begin
      n_err++; $display("FAIL reach_show: state=%0d want 3", state); return;
    end
    n_cmp++;
    if (led !== pat) begin n_err++; $display("FAIL show_pattern: led=%b want %b", led, pat); end
    show_len = 0;
    while (state === 3'd3 && show_len < 200) begin step(); show_len++; end
    n_cmp++;
    if (show_len !== m_show()) begin
      n_err++; $display("FAIL show_len: got %0d want %0d (level %0d)", show_len, m_show(), m_level);
    end
    n_cmp++;
    if (state !== 3'd4 || led !== '0) begin
      n_err++; $display("FAIL wait_entry: state=%0d led=%b want 4/0", state, led); return;
    end
    case (mode)
      0: d = $urandom_range(1, 20);
      1: d = BASE_WINDOW - 2;
      3: d = BASE_WINDOW - 1;
      default: d = 1000;
    endcase
    exp_hit = (d + 2 <= BASE_WINDOW);
    wrong = N'($urandom);
    if (wrong == pat) wrong = wrong ^ N'(1);
    wait_len = 0;
    while (state === 3'd4 && wait_len < 200) begin
      wait_len++;
      if (wait_len == 1 && d > 1 && mode != 2) sw = wrong;
      if (wait_len == d) sw = pat;
      step();
    end
    if (exp_hit) begin
      n_cmp++;
      if (state !== 3'd5 || wait_len !== d + 2) begin
        n_err++; $display("FAIL hit_entry: state=%0d wait=%0d want 5/%0d", state, wait_len, d + 2);
      end
      n_cmp++;
      if (led !== all1) begin n_err++; $display("FAIL hit_led: led=%b want all ones", led); end
      m_hit();
      step();
      n_cmp++;
      if (state !== 3'd1 || led !== '0) begin
        n_err++; $display("FAIL hit_one_cycle: state=%0d led=%b want 1/0", state, led);
      end
      n_cmp++;
      if (level !== 4'(m_level) || seg_tens !== seg_tab[m_score / 10] || seg_ones !== seg_tab[m_score % 10]) begin
        n_err++; $display("FAIL score_update: level=%0d tens=%b ones=%b want score %0d level %0d",
                          level, seg_tens, seg_ones, m_score, m_level);
      end
    end else begin
      n_cmp++;
      if (state !== 3'd6 || wait_len !== BASE_WINDOW || game_over !== 1'b1) begin
        n_err++; $display("FAIL over_entry: state=%0d wait=%0d go=%b want 6/%0d/1",
                          state, wait_len, game_over, BASE_WINDOW);
      end
      p0 = led;
      n_cmp++;
      if (p0 !== alt_a && p0 !== ~alt_a) begin n_err++; $display("FAIL over_led: led=%b want alternating", p0); end
      repeat (15) step();
      n_cmp++;
      if (led !== p0) begin n_err++; $display("FAIL blink_hold: led=%b want %b", led, p0); end
      step();
      n_cmp++;
      if (led !== ~p0) begin n_err++; $display("FAIL blink_toggle: led=%b want %b", led, ~p0); end
      n_cmp++;
      if (seg_tens !== seg_tab[m_score / 10] || seg_ones !== seg_tab[m_score % 10]) begin
        n_err++; $display("FAIL score_frozen: tens=%b ones=%b want score %0d", seg_tens, seg_ones, m_score);
      end
    end
  endtask

  task automatic restart_game();
    start = 1'b0;
    step();
    n_cmp++;
    if (state !== 3'd0 || game_over !== 1'b0 || led !== '0) begin
      n_err++; $display("FAIL over_to_idle: state=%0d go=%b led=%b want 0/0/0", state, game_over, led);
    end
    n_cmp++;
    if (seg_tens !== seg_tab[m_score / 10] || seg_ones !== seg_tab[m_score % 10]) begin
      n_err++; $display("FAIL idle_score: tens=%b ones=%b want score %0d", seg_tens, seg_ones, m_score);
    end
    start = 1'b1;
    step();
    m_reset_game();
    n_cmp++;
    if (state !== 3'd1 || seg_tens !== seg_tab[0] || seg_ones !== seg_tab[0] || level !== 4'd0) begin
      n_err++; $display("FAIL restart_clear: state=%0d tens=%b ones=%b level=%0d want 1/00/0",
                        state, seg_tens, seg_ones, level);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sw = '0;
    step(); step();
    reset = 1'b0;
    m_lfsr = SEED; m_reset_game();
    n_cmp++;
    if (state !== 3'd0 || led !== '0 || level !== 4'd0 || game_over !== 1'b0 ||
        seg_tens !== 7'b1000000 || seg_ones !== 7'b1000000) begin
      n_err++; $display("FAIL reset_state: state=%0d led=%b level=%0d go=%b tens=%b ones=%b",
                        state, led, level, game_over, seg_tens, seg_ones);
    end
  endtask

  task automatic test_first_hit();
    start = 1'b1;
    step();
    play_round(0);
    n_cmp++;
    if (seg_ones !== 7'b1111001 || seg_tens !== 7'b1000000) begin
      n_err++; $display("FAIL first_hit_seg: tens=%b ones=%b want 1000000/1111001", seg_tens, seg_ones);
    end
  endtask

  task automatic test_level_up();
    repeat (3) play_round(0);
    n_cmp++;
    if (level !== 4'd1) begin n_err++; $display("FAIL level_up: level=%0d want 1", level); end
    repeat (4) play_round(0);
    n_cmp++;
    if (level !== 4'd2) begin n_err++; $display("FAIL level_two: level=%0d want 2", level); end
  endtask

  task automatic test_reset_mid_show();
    int k;
    sw = '0;
    k = 0;
    while (state !== 3'd3 && k < 60) begin step(); k++; end
    n_cmp++;
    if (state !== 3'd3) begin n_err++; $display("FAIL mid_show_reach: state=%0d want 3", state); end
    step(); step();
    reset = 1'b1; start = 1'b0;
    step();
    reset = 1'b0;
    m_lfsr = SEED; m_reset_game();
    n_cmp++;
    if (state !== 3'd0 || level !== 4'd0 || led !== '0 || seg_tens !== 7'b1000000 || seg_ones !== 7'b1000000) begin
      n_err++; $display("FAIL mid_show_reset: state=%0d level=%0d led=%b tens=%b ones=%b",
                        state, level, led, seg_tens, seg_ones);
    end
  endtask

  task automatic test_timeout();
    start = 1'b1;
    step();
    play_round(0);
    play_round(2);
    restart_game();
  endtask

  task automatic test_late_match();
    play_round(1);
    play_round(3);
    restart_game();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 100; i++) begin
      play_round((i % 7 == 3) ? 1 : 0);
    end
    n_cmp++;
    if (seg_tens !== 7'b0010000 || seg_ones !== 7'b0010000 || level !== 4'd7) begin
      n_err++; $display("FAIL saturate: tens=%b ones=%b level=%0d want 99 / level 7", seg_tens, seg_ones, level);
    end
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_level_up();
    test_reset_mid_show();
    test_timeout();
    test_late_match();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
